mer_calc_log: RTL and testbench

Parametrised successor to the fixed-range MER lookup. Accepts one (mapper_power, error_power) pair per handshake and computes MER = 10*log10(mapper_power/error_power) in signed fixed-point dB. It uses leading-one detection plus a small log2-fraction LUT, so any positive input in the full input width is valid. Sits after the mapper/error power averagers and feeds the MER display/telemetry path.

---
 rtl/mer_calc_log_if.sv | 26 ++
 rtl/mer_calc_log.sv | 190 +++++++++++++++++++
 tb/tb_mer_calc_log.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mer_calc_log_if.sv
`default_nettype none
// mer_calc_log_if: power-pair request and MER result bundle for mer_calc_log.
// Rev 1.0
interface mer_calc_log_if #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 11
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  mapper_power;
  logic signed [IN_W-1:0]  error_power;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_mer;
  logic                    out_err;

  modport master (
    output in_valid, mapper_power, error_power,
    input  in_ready, out_valid, out_mer, out_err
  );

  modport slave (
    input  in_valid, mapper_power, error_power,
    output in_ready, out_valid, out_mer, out_err
  );
endinterface
`default_nettype wire

// File: rtl/mer_calc_log.sv
`default_nettype none
// mer_calc_log: MER = 10*log10(P/E) in signed fixed-point dB via leading-one detect + log2 LUT.
// Rev 1.0
module mer_calc_log #(
  parameter int IN_W     = 18,
  parameter int LUT_BITS = 6,
  parameter int LF       = 8,
  parameter int OUT_W    = 11,
  parameter int FRAC_W   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  mer_calc_log_if.slave bus
);

  localparam int MSBW = $clog2(IN_W);
  localparam int LW   = MSBW + LF;
  localparam int DW   = LW + 1;
  localparam int PW   = DW + 16;
  localparam int SH   = LF + 12 - FRAC_W;
  localparam int LUTW = LF + 1;
  localparam int NLUT = 2 ** LUT_BITS;

  localparam logic signed [15:0]   c_k    = 16'sd12330;
  localparam logic signed [PW-1:0] c_half = PW'(1) << (SH - 1);
  localparam logic signed [PW-1:0] c_max  = PW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PW-1:0] c_min  = -PW'(2 ** (OUT_W - 1));
  localparam logic [OUT_W-1:0]     c_pos  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     c_neg  = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOG_P = 3'd1,
    S_LOG_E = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Elaboration-time log2(1 + k/2^LUT_BITS) by repeated squaring, rounded half up to LF bits.
  function automatic logic [LUTW-1:0] f_lut_entry(input int k);
    logic [63:0] y;
    logic [31:0] acc;
    y   = 64'((2 ** LUT_BITS) + k) << (30 - LUT_BITS);
    acc = '0;
    for (int i = 0; i < LF + 8; i++) begin
      y   = (y * y) >> 30;
      acc = acc << 1;
      if (y >= (64'd2 << 30)) begin
        acc[0] = 1'b1;
        y      = y >> 1;
      end
    end
    return LUTW'((acc + 32'd128) >> 8);
  endfunction

  state_t                 r_state;
  state_t                 w_next;
  logic [IN_W-1:0]        r_p;
  logic [IN_W-1:0]        r_e;
  logic                   r_err_p;
  logic                   r_err_e;
  logic [LW-1:0]          r_lp;
  logic [LW-1:0]          r_le;
  logic signed [PW-1:0]   r_prod;
  logic [OUT_W-1:0]       r_out_mer;
  logic                   r_out_err;
  logic                   r_out_valid;

  logic                   w_p_bad;
  logic                   w_e_bad;
  logic [IN_W-1:0]        w_log_in;
  logic [IN_W+LUT_BITS-2:0] w_pad;
  logic [MSBW-1:0]        w_msb;
  logic [LUT_BITS-1:0]    w_idx;
  logic [LUTW-1:0]        w_lut [NLUT];
  logic [LW-1:0]          w_log;
  logic signed [DW-1:0]   w_d;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_rnd;
  logic [OUT_W-1:0]       w_sat;

  for (genvar g = 0; g < NLUT; g++) begin : g_lut
    assign w_lut[g] = f_lut_entry(g);
  end

  assign w_p_bad = bus.mapper_power[IN_W-1] | (bus.mapper_power == '0);
  assign w_e_bad = bus.error_power[IN_W-1]  | (bus.error_power == '0);

  // One shared log unit; the operand follows the state.
  assign w_log_in = (r_state == S_LOG_E) ? r_e : r_p;
  assign w_pad    = {w_log_in[IN_W-2:0], {LUT_BITS{1'b0}}};

  always_comb begin
    w_msb = '0;
    w_idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (w_log_in[i]) begin
        w_msb = MSBW'(i);
        w_idx = w_pad[i +: LUT_BITS];
      end
    end
  end

  assign w_log  = {w_msb, {LF{1'b0}}} + LW'(w_lut[w_idx]);
  assign w_d    = $signed({1'b0, r_lp}) - $signed({1'b0, r_le});
  assign w_prod = PW'(w_d) * PW'(c_k);
  assign w_rnd  = (r_prod + c_half) >>> SH;

  always_comb begin
    w_sat = w_rnd[OUT_W-1:0];
    if (w_rnd > c_max) begin
      w_sat = c_pos;
    end else if (w_rnd < c_min) begin
      w_sat = c_neg;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = (w_p_bad | w_e_bad) ? S_DONE : S_LOG_P;
      S_LOG_P: w_next = S_LOG_E;
      S_LOG_E: w_next = S_SCALE;
      S_SCALE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p         <= '0;
      r_e         <= '0;
      r_err_p     <= 1'b0;
      r_err_e     <= 1'b0;
      r_lp        <= '0;
      r_le        <= '0;
      r_prod      <= '0;
      r_out_mer   <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (clk_en) begin
        case (r_state)
          S_IDLE: begin
            if (bus.in_valid) begin
              r_p     <= bus.mapper_power;
              r_e     <= bus.error_power;
              r_err_p <= w_p_bad;
              r_err_e <= w_e_bad;
            end
          end
          S_LOG_P: r_lp   <= w_log;
          S_LOG_E: r_le   <= w_log;
          S_SCALE: r_prod <= w_prod;
          S_DONE: begin
            r_out_valid <= 1'b1;
            r_out_err   <= r_err_p | r_err_e;
            // A non-positive mapper power outranks a non-positive error power.
            if (r_err_p) begin
              r_out_mer <= c_neg;
            end else if (r_err_e) begin
              r_out_mer <= c_pos;
            end else begin
              r_out_mer <= w_sat;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_mer   = r_out_mer;
  assign bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_mer_calc_log.sv
`default_nettype none
// tb_mer_calc_log: table vectors, randomized pairs against a log-domain reference, throttle and reset sequences.
// Rev 1.0
module tb_mer_calc_log;
  localparam int IN_W  = 18;
  localparam int OUT_W = 11;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  int   en_period = 1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  mer_calc_log_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  mer_calc_log #(
    .IN_W(IN_W), .LUT_BITS(6), .LF(8), .OUT_W(OUT_W), .FRAC_W(4)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .clk_en(clk_en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int e;
    int mer;
    int err;
  } vec_t;

  vec_t tbl [7];

  function automatic int lut_ref(input int k);
    real r;
    r = $ln(1.0 + real'(k) / 64.0) / $ln(2.0) * 256.0;
    return $rtoi($floor(r + 0.5));
  endfunction

  function automatic int log_ref(input int x);
    int m;
    int k;
    m = 0;
    while ((x >> (m + 1)) != 0) m++;
    k = $rtoi((real'(x) / (2.0 ** m) - 1.0) * 64.0);
    return m * 256 + lut_ref(k);
  endfunction

  task automatic ref_mer(input int p, input int e, output int mer, output int err);
    int d;
    if (p <= 0) begin
      mer = -1024; err = 1;
    end else if (e <= 0) begin
      mer = 1023; err = 1;
    end else begin
      d   = log_ref(p) - log_ref(e);
      mer = $rtoi($floor(real'(d) * 12330.0 / 65536.0 + 0.5));
      if (mer > 1023) mer = 1023;
      if (mer < -1024) mer = -1024;
      err = 0;
    end
  endtask

  function automatic int rnd_pow();
    int r;
    int v;
    r = int'($urandom_range(0, 11));
    if (r == 0) return 0;
    if (r == 1) return -int'($urandom_range(1, 5000));
    v = int'($urandom_range(1, 131071) >> $urandom_range(0, 16));
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    clk_en = (en_period <= 1) || (cyc % en_period == 0);
  endtask

  // Transfers one pair and waits for the result; lat counts enabled edges after the transfer edge.
  task automatic do_pair(input int p, input int e, output int mer, output int err, output int lat);
    int guard;
    bit en;
    bus.mapper_power = IN_W'(p);
    bus.error_power  = IN_W'(e);
    bus.in_valid     = 1'b1;
    guard = 0;
    while (!(clk_en && bus.in_ready) && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = -1;
    guard = 0;
    begin : wait_out
      int n;
      n = 0;
      while (guard < 200) begin
        en = clk_en;
        tick();
        guard++;
        if (en) n++;
        if (bus.out_valid) begin
          lat = n;
          break;
        end
      end
    end
    mer = int'($signed(bus.out_mer));
    err = int'(bus.out_err);
    tick();
    check("valid_pulse_width", int'(bus.out_valid), 0);
  endtask

  task automatic apply(input string name, input int p, input int e, input int exp_mer, input int exp_err);
    int mer, err, lat;
    do_pair(p, e, mer, err, lat);
    check({name, "_mer"}, mer, exp_mer);
    check({name, "_err"}, err, exp_err);
    check({name, "_lat"}, lat, (exp_err != 0) ? 1 : 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int p, e, em, ee, n_en, pulses, busy, guard, seen;
    bit en, rdy;

    rst_n = 1'b0;
    clk_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.mapper_power = '0;
    bus.error_power = '0;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_mer", int'($signed(bus.out_mer)), 0);
    check("rst_out_err", int'(bus.out_err), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    tbl[0] = '{1024, 1024, 0, 0};
    tbl[1] = '{2048, 2, 482, 0};
    tbl[2] = '{4096, 1, 578, 0};
    tbl[3] = '{2, 2048, -482, 0};
    tbl[4] = '{1000, 0, 1023, 1};
    tbl[5] = '{-5, 0, -1024, 1};
    tbl[6] = '{1024, 1024, 0, 0};

    foreach (tbl[i]) begin
      apply($sformatf("tbl%0d", i), tbl[i].p, tbl[i].e, tbl[i].mer, tbl[i].err);
    end

    // Each random pair runs at full rate and at a 1-in-4 enable rate.
    for (int i = 0; i < 30; i++) begin
      p = rnd_pow();
      e = rnd_pow();
      ref_mer(p, e, em, ee);
      en_period = 1;
      apply($sformatf("rnd%0d_full p=%0d e=%0d", i, p, e), p, e, em, ee);
      en_period = 4;
      apply($sformatf("rnd%0d_thr p=%0d e=%0d", i, p, e), p, e, em, ee);
    end

    // in_valid held high under a 1-in-4 enable: one result per five enabled cycles.
    en_period = 4;
    bus.mapper_power = IN_W'(4096);
    bus.error_power  = IN_W'(1);
    bus.in_valid     = 1'b1;
    guard = 0;
    while (!(clk_en && bus.in_ready) && guard < 50) begin
      tick();
      guard++;
    end
    n_en = 0; pulses = 0; busy = 0; guard = 0;
    while (n_en < 50 && guard < 1000) begin
      en  = clk_en;
      rdy = bus.in_ready;
      tick();
      guard++;
      if (en) begin
        n_en++;
        if (!rdy) busy++;
      end
      if (bus.out_valid) begin
        pulses++;
        check("hold_mer", int'($signed(bus.out_mer)), 578);
      end
    end
    bus.in_valid = 1'b0;
    check("hold_enabled_cycles", n_en, 50);
    check("hold_results", pulses, 10);
    check("hold_busy_cycles", busy, 40);
    repeat (8) tick();

    // Reset while the SCALE step is pending.
    en_period = 1;
    apply("pre_rst", 2048, 2, 482, 0);
    bus.mapper_power = IN_W'(1000);
    bus.error_power  = IN_W'(3);
    bus.in_valid     = 1'b1;
    guard = 0;
    while (!(clk_en && bus.in_ready) && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_out_mer", int'($signed(bus.out_mer)), 0);
    check("mid_rst_out_err", int'(bus.out_err), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("post_rst_no_valid", seen, 0);
    ref_mer(1000, 3, em, ee);
    apply("post_rst", 1000, 3, em, ee);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
